// File: rtl/aes_core_arbiter.sv
// Two-requester arbiter around a shared combinational AES-128 encrypt core (multicycle settle).
// Optional build macro AES_FIXED_PRIO_EN: requester 0 always wins a tie instead of round-robin.
module aes_core_arbiter #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_data,
  output logic [127:0] core_datain,
  output logic [127:0] core_key,
  input  logic [127:0] core_dataout,
  output logic         busy
);

  localparam logic [1:0]       IDLE     = 2'd0;
  localparam logic [1:0]       WAIT     = 2'd1;
  localparam logic [1:0]       RESP     = 2'd2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             rr_ptr_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [127:0]     core_datain_q;
  logic [127:0]     core_key_q;
  logic [127:0]     result_q;
  logic             any_req_s;
  logic             grant_s;
  logic             accept_s;
  logic             rsp_hs_s;

  assign any_req_s = req0_valid | req1_valid;

`ifdef AES_FIXED_PRIO_EN
  assign grant_s = req1_valid & ~req0_valid;
`else
  // grant_s is the winning requester index; rr_ptr_q breaks ties
  assign grant_s = req1_valid & (~req0_valid | rr_ptr_q);
`endif

  assign accept_s = (state_q == IDLE) & any_req_s;
  assign rsp_hs_s = (state_q == RESP) & (owner_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req_s) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_hs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        req0_ready = any_req_s & ~grant_s;
        req1_ready = grant_s;
        busy       = 1'b0;
      end
      WAIT: busy = 1'b1;
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
      end
      default: busy = 1'b1;
    endcase
  end

  // Core inputs stay frozen from accept until the next accept, giving the core its settle window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_datain_q <= 128'd0;
      core_key_q    <= 128'd0;
      owner_q       <= 1'b0;
      cnt_q         <= '0;
      result_q      <= 128'd0;
      rr_ptr_q      <= 1'b0;
    end else begin
      if (accept_s) begin
        core_datain_q <= grant_s ? req1_data : req0_data;
        core_key_q    <= grant_s ? req1_key : req0_key;
        owner_q       <= grant_s;
        cnt_q         <= CNT_INIT;
      end
      if (state_q == WAIT) begin
        if (cnt_q == '0) begin
          result_q <= core_dataout;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
      if (rsp_hs_s) begin
`ifdef AES_FIXED_PRIO_EN
        rr_ptr_q <= 1'b0;
`else
        rr_ptr_q <= ~owner_q;
`endif
      end
    end
  end

  assign core_datain = core_datain_q;
  assign core_key    = core_key_q;
  assign rsp0_data   = result_q;
  assign rsp1_data   = result_q;

endmodule
